// File: rtl/iob_cache_bus_initiator.sv
// IOb bus initiator for the cache: one outstanding transaction,
// registered request fields, read-response timeout and sticky error flag.
module iob_cache_bus_initiator #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_wstrb_i,
    input  logic [3:0]          cmd_acache_i,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    output logic [3:0]          iob_acache_o,
    input  logic                iob_ready_i,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    input  logic                rsp_ready_i,
    output logic                err_o
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] RWAIT = 2'd2;
    localparam logic [1:0] RSP   = 2'd3;

    localparam logic [TIMEOUT_W-1:0] CNT_ALL = '1;

    logic [1:0]           state_q,  state_d;
    logic [TIMEOUT_W-1:0] cnt_q,    cnt_d;
    logic [ADDR_W-1:0]    addr_q,   addr_d;
    logic [DATA_W-1:0]    wdata_q,  wdata_d;
    logic [STRB_W-1:0]    wstrb_q,  wstrb_d;
    logic [3:0]           acache_q, acache_d;
    logic [DATA_W-1:0]    rdata_q,  rdata_d;
    logic                 rerr_q,   rerr_d;
    logic                 err_q,    err_d;
    logic [TIMEOUT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + TIMEOUT_W'(1);

    // Next-state and datapath: the timeout fires on the wait cycle in
    // which the counter reaches all ones, unless rvalid arrives then.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        acache_d = acache_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (iob_rvalid_i) err_d = 1'b1;
                if (cmd_valid_i) begin
                    addr_d   = cmd_addr_i;
                    wdata_d  = cmd_wdata_i;
                    wstrb_d  = cmd_wstrb_i;
                    acache_d = cmd_acache_i;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (iob_rvalid_i) err_d = 1'b1;
                if (iob_ready_i) begin
                    cnt_d   = '0;
                    state_d = (|wstrb_q) ? IDLE : RWAIT;
                end
            end
            RWAIT: begin
                if (iob_rvalid_i) begin
                    rdata_d = iob_rdata_i;
                    rerr_d  = 1'b0;
                    state_d = RSP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_ALL) begin
                        rdata_d = '0;
                        rerr_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = RSP;
                    end
                end
            end
            RSP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, frozen while the clock enable is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            acache_q <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (cke_i) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            acache_q <= acache_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready_o  = (state_q == IDLE);
    assign iob_avalid_o = (state_q == REQ);
    assign rsp_valid_o  = (state_q == RSP);
    assign iob_addr_o   = addr_q;
    assign iob_wdata_o  = wdata_q;
    assign iob_wstrb_o  = wstrb_q;
    assign iob_acache_o = acache_q;
    assign rsp_rdata_o  = rdata_q;
    assign rsp_err_o    = rerr_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_iob_cache_bus_initiator.sv
// Directed and randomized bench for iob_cache_bus_initiator,
// checked against a transaction-level model with a 3-bit timeout.
module tb_iob_cache_bus_initiator;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TW   = 3;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          cke = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic [3:0]    cmd_acache = '0;
    logic          iob_avalid;
    logic [AW-1:0] iob_addr;
    logic [DW-1:0] iob_wdata;
    logic [3:0]    iob_wstrb;
    logic [3:0]    iob_acache;
    logic          iob_ready = 1'b0;
    logic          iob_rvalid = 1'b0;
    logic [DW-1:0] iob_rdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_ready = 1'b0;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_err = 1'b0;

    iob_cache_bus_initiator #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .cmd_wstrb_i(cmd_wstrb), .cmd_acache_i(cmd_acache),
        .iob_avalid_o(iob_avalid), .iob_addr_o(iob_addr),
        .iob_wdata_o(iob_wdata), .iob_wstrb_o(iob_wstrb),
        .iob_acache_o(iob_acache), .iob_ready_i(iob_ready),
        .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_ready_i(rsp_ready),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #3;
        arst_n = 1'b1;
        exp_err = 1'b0;
        tick();
    endtask

    // One full transaction: rdy_dly stall cycles before IOb accepts,
    // rvalid on wait cycle rv_dly (outside 1..TMAX means never),
    // stall cycles of response backpressure.
    task automatic run_txn(input string tag, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input logic [3:0] ac, input int rdy_dly,
                           input int rv_dly, input logic [31:0] rd,
                           input int stall);
        logic ok;
        chk({tag, ".idle_rdy"}, cmd_ready, 1);
        chk({tag, ".idle_av"}, iob_avalid, 0);
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        cmd_acache = ac;
        tick();
        cmd_valid = 1'b0;
        cmd_addr = ~a;
        cmd_wdata = ~wd;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk({tag, ".av"}, iob_avalid, 1);
            chk({tag, ".addr"}, iob_addr, a);
            chk({tag, ".wdata"}, iob_wdata, wd);
            chk({tag, ".wstrb"}, iob_wstrb, ws);
            chk({tag, ".acache"}, iob_acache, ac);
            chk({tag, ".req_rdy"}, cmd_ready, 0);
            iob_ready = (i == rdy_dly);
            tick();
        end
        iob_ready = 1'b0;
        if (ws != 0) begin
            chk({tag, ".wr_rdy"}, cmd_ready, 1);
            chk({tag, ".wr_av"}, iob_avalid, 0);
            chk({tag, ".wr_rsp"}, rsp_valid, 0);
            return;
        end
        ok = 1'b0;
        for (int k = 1; k <= TMAX; k++) begin
            chk({tag, ".wait_av"}, iob_avalid, 0);
            chk({tag, ".wait_rsp"}, rsp_valid, 0);
            iob_rvalid = (k == rv_dly);
            iob_rdata = (k == rv_dly) ? rd : 32'hA5A5_A5A5;
            tick();
            iob_rvalid = 1'b0;
            if (k == rv_dly) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) exp_err = 1'b1;
        for (int s = 0; s <= stall; s++) begin
            chk({tag, ".rsp_v"}, rsp_valid, 1);
            chk({tag, ".rsp_d"}, rsp_rdata, ok ? rd : 0);
            chk({tag, ".rsp_e"}, rsp_err, !ok);
            chk({tag, ".rsp_cr"}, cmd_ready, 0);
            chk({tag, ".err"}, err, exp_err);
            rsp_ready = (s == stall);
            tick();
        end
        rsp_ready = 1'b0;
        chk({tag, ".end_rdy"}, cmd_ready, 1);
        chk({tag, ".end_rsp"}, rsp_valid, 0);
    endtask

    initial begin
        #2;
        chk("rst.cmd_ready", cmd_ready, 1);
        chk("rst.avalid", iob_avalid, 0);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.addr", iob_addr, 0);
        chk("rst.wdata", iob_wdata, 0);
        chk("rst.wstrb", iob_wstrb, 0);
        chk("rst.acache", iob_acache, 0);
        chk("rst.rdata", rsp_rdata, 0);
        chk("rst.rsp_err", rsp_err, 0);
        chk("rst.err", err, 0);
        do_reset();

        run_txn("wr", 32'h100, 32'hDEAD_BEEF, 4'hF, 4'h3, 0, 0, 0, 0);
        run_txn("rd_bp", 32'h200, 32'h0, 4'h0, 4'h5, 3, 2,
                32'h1234_5678, 0);
        run_txn("rsp_stall", 32'h300, 32'h0, 4'h0, 4'h1, 0, 1,
                32'hCAFE_0001, 5);
        run_txn("edge_rv", 32'h400, 32'h0, 4'h0, 4'h2, 1, TMAX,
                32'h0BAD_F00D, 0);
        chk("edge_rv.err", err, 0);
        run_txn("timeout", 32'h500, 32'h0, 4'h0, 4'h7, 0, 0,
                32'h0, 1);
        chk("timeout.err_sticky", err, 1);
        run_txn("after_to", 32'h504, 32'h0, 4'h0, 4'h0, 0, 3,
                32'h7777_8888, 0);

        do_reset();
        chk("spur.pre", err, 0);
        iob_rvalid = 1'b1;
        tick();
        iob_rvalid = 1'b0;
        exp_err = 1'b1;
        chk("spur.err", err, 1);
        chk("spur.cmd_ready", cmd_ready, 1);
        chk("spur.avalid", iob_avalid, 0);

        cmd_valid = 1'b1;
        cmd_addr = 32'h600;
        cmd_wstrb = 4'h0;
        tick();
        cmd_valid = 1'b0;
        chk("mid.avalid", iob_avalid, 1);
        arst_n = 1'b0;
        #1;
        chk("mid.avalid_drop", iob_avalid, 0);
        chk("mid.err_clr", err, 0);
        chk("mid.cmd_ready", cmd_ready, 1);
        chk("mid.addr", iob_addr, 0);
        arst_n = 1'b1;
        exp_err = 1'b0;
        tick();
        iob_rvalid = 1'b1;
        tick();
        iob_rvalid = 1'b0;
        chk("abandon.err", err, 1);

        do_reset();
        cmd_valid = 1'b1;
        cmd_addr = 32'h700;
        cmd_wdata = 32'h1111_2222;
        cmd_wstrb = 4'h3;
        tick();
        cmd_valid = 1'b0;
        cke = 1'b0;
        iob_ready = 1'b1;
        iob_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cke.avalid", iob_avalid, 1);
            chk("cke.addr", iob_addr, 32'h700);
            chk("cke.err", err, 0);
        end
        iob_rvalid = 1'b0;
        cke = 1'b1;
        tick();
        iob_ready = 1'b0;
        chk("cke.done", cmd_ready, 1);
        chk("cke.av_low", iob_avalid, 0);

        do_reset();
        for (int t = 0; t < 30; t++) begin
            logic [3:0] ws;
            ws = ($urandom_range(0, 1) == 0) ? 4'h0
                 : 4'($urandom_range(1, 15));
            run_txn("rnd", $urandom, $urandom, ws,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3),
                    $urandom_range(1, TMAX + 2), $urandom,
                    $urandom_range(0, 2));
            chk("rnd.err", err, exp_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_cache_bus_initiator.md
IOB_CACHE_BUS_INITIATOR -- requirements
Module: iob_cache_bus_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, IOb address width.
REQ-002 SHALL have parameter DATA_W, default 32, IOb data width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_W, default 8, width of read-response timeout counter.
REQ-004 clk_i  in  1  clock; all state on rising edge; one clock domain.
REQ-005 arst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 cke_i  in  1  clock enable; when 0 all registers hold.
REQ-007 cmd_valid_i  in  1  command present.
REQ-008 cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
REQ-009 cmd_addr_i / cmd_wdata_i / cmd_wstrb_i / cmd_acache_i  in  ADDR_W / DATA_W / DATA_W/8 / 4  command fields; wstrb==0 means read.
REQ-010 iob_avalid_o  out  1  IOb request valid.
REQ-011 iob_addr_o / iob_wdata_o / iob_wstrb_o / iob_acache_o  out  ADDR_W / DATA_W / DATA_W/8 / 4  IOb request fields.
REQ-012 iob_ready_i  in  1  responder accepts request when iob_avalid_o & iob_ready_i.
REQ-013 iob_rvalid_i / iob_rdata_i  in  1 / DATA_W  read response.
REQ-014 rsp_valid_o / rsp_rdata_o / rsp_err_o  out  1 / DATA_W / 1  read result to user.
REQ-015 rsp_ready_i  in  1  user consumes result when rsp_valid_o & rsp_ready_i.
REQ-016 err_o  out  1  sticky protocol error flag.

Function
REQ-017 SHALL implement FSM IDLE, REQ, RWAIT, RSP; at most one IOb transaction outstanding.
REQ-018 cmd_ready_o SHALL equal (state==IDLE); on accept, all cmd fields SHALL be registered and state -> REQ.
REQ-019 iob_avalid_o SHALL equal (state==REQ), registered-output timing: first avalid cycle is the cycle after command acceptance.
REQ-020 iob_addr/wdata/wstrb/acache_o SHALL be driven from registered fields, stable for the entire REQ state.
REQ-021 In REQ with iob_ready_i=0, state SHALL remain REQ (avalid held, fields unchanged).
REQ-022 In REQ with iob_ready_i=1: write (|wstrb) -> IDLE; read -> RWAIT with timeout counter cleared to 0.
REQ-023 iob_rvalid_i SHALL be ignored in any cycle where state!=RWAIT, including the acceptance cycle itself; if sampled 1 in IDLE or REQ, err_o SHALL set.
REQ-024 In RWAIT with iob_rvalid_i=1: iob_rdata_i SHALL be captured into rsp_rdata_o, rsp_err_o=0, state -> RSP.
REQ-025 In RWAIT with iob_rvalid_i=0: counter increments; when counter equals 2^TIMEOUT_W-1 (all ones) state -> RSP with rsp_rdata_o=0, rsp_err_o=1, err_o set.
REQ-026 rvalid arriving in the same cycle the counter is all ones SHALL take priority (normal response, no error).
REQ-027 rsp_valid_o SHALL equal (state==RSP); rsp_rdata_o/rsp_err_o stable while in RSP.
REQ-028 In RSP with rsp_ready_i=1 state -> IDLE; new command accepted no earlier than the following cycle.
REQ-029 Read command to IOb avalid latency: 1 cycle; read rvalid to rsp_valid_o: 1 cycle; write accept-to-cmd_ready_o reasserted: 1 cycle.
REQ-030 err_o SHALL remain 1 until reset; no other clear path.
REQ-031 cke_i=0 SHALL freeze FSM, counter, registers, and err_o; outputs reflect frozen state.

Reset
REQ-032 arst_n_i=0 SHALL asynchronously force state=IDLE, counter=0, all registered fields=0, err_o=0, rsp_err_o=0.
REQ-033 Reset values: cmd_ready_o=1 (after release), iob_avalid_o=0, rsp_valid_o=0, iob_* fields=0, rsp_rdata_o=0.
REQ-034 Reset mid-transaction SHALL abandon it; a later iob_rvalid_i in IDLE SHALL set err_o.

Verification
REQ-035 Write: cmd addr=0x100, wdata=0xDEADBEEF, wstrb=0xF, iob_ready_i=1 -> avalid 1 cycle with those fields, no rsp_valid_o, cmd_ready_o=1 next cycle.
REQ-036 Read with backpressure: ready low 3 cycles, rvalid 2 cycles after accept, rdata=0x12345678 -> avalid held 4 cycles, fields stable, rsp_valid_o rdata=0x12345678 rsp_err_o=0.
REQ-037 Response stall: rsp_ready_i=0 for 5 cycles -> rsp_valid_o/rdata held, cmd_ready_o=0 throughout.
REQ-038 Timeout, TIMEOUT_W=3: read accepted, no rvalid -> rsp_valid_o after 7 RWAIT cycles with rsp_err_o=1, rdata=0, err_o=1.
REQ-039 Spurious rvalid in IDLE -> err_o=1, FSM unaffected; async reset mid-REQ -> avalid drops immediately, err_o=0.
REQ-040 Boundary: rvalid exactly on the all-ones timeout count -> normal response, rsp_err_o=0.
